// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC start/stop pair scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdc_pkg;

    localparam int STAMP_W_DEF = 37;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_B = 2'd1,
        ST_SEND_A = 2'd2,
        ST_SEND_B = 2'd3
    } tdc_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tdc_wdog.sv
// Stop-stamp watchdog: counts cycles spent waiting, flags expiry at TIMEOUT-1.
// Latency: expired is combinational from the count, count updates each clk.
// Backpressure: none; clr has priority over run.
module tdc_wdog
    import tdc_pkg::*;
#(
    parameter logic [CNT_W-1:0] TIMEOUT = 16'd2000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    assign expired = run && (cnt == TIMEOUT - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/tdc_pair_sched.sv
// Pairs start/stop stamps and emits them as adjacent start/stop words; TDC_PAIR_TIMEOUT_EN adds a stop-wait watchdog.
// Latency: stop sampled in cycle N -> start word in N+1, stop word in N+2.
// Backpressure: none; strobes that cannot be accepted are dropped and counted in drop_cnt.
module tdc_pair_sched
    import tdc_pkg::*;
#(
    parameter int               STAMP_W = STAMP_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT = 16'd2000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               a_vld,
    input  logic [STAMP_W-1:0] a_stamp,
    input  logic               b_vld,
    input  logic [STAMP_W-1:0] b_stamp,
    output logic               o_dval,
    output logic [STAMP_W-1:0] o_mlt,
    output logic               o_phase,
    output logic               busy,
    output logic [CNT_W-1:0]   pair_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);

    tdc_state_e         state, state_nxt;
    logic [STAMP_W-1:0] a_q, a_nxt;
    logic [STAMP_W-1:0] b_q, b_nxt;
    logic               drop;

`ifdef TDC_PAIR_TIMEOUT_EN
    logic wdog_run;
    logic wdog_clr;
    logic wdog_expired;

    assign wdog_run = (state == ST_WAIT_B);
    assign wdog_clr = !wdog_run;

    tdc_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdog_clr),
        .run     (wdog_run),
        .expired (wdog_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        drop      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && a_vld) begin
                    a_nxt = a_stamp;
                    if (b_vld) begin
                        b_nxt     = b_stamp;
                        state_nxt = ST_SEND_A;
                    end else begin
                        state_nxt = ST_WAIT_B;
                    end
                end else if (b_vld) begin
                    drop = 1'b1;
                end
            end
            ST_WAIT_B: begin
                // A second start never replaces the first; it only counts as a drop.
                drop = a_vld;
                if (b_vld) begin
                    b_nxt     = b_stamp;
                    state_nxt = ST_SEND_A;
                end
`ifdef TDC_PAIR_TIMEOUT_EN
                else if (!en || wdog_expired) begin
                    drop      = 1'b1;
                    state_nxt = ST_IDLE;
                end
`endif
            end
            ST_SEND_A: begin
                drop      = a_vld || b_vld;
                state_nxt = ST_SEND_B;
            end
            ST_SEND_B: begin
                drop      = a_vld || b_vld;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            o_mlt    <= '0;
            pair_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
            // Word register is loaded on entry to each send state so it holds between pairs.
            if (state_nxt == ST_SEND_A) begin
                o_mlt <= a_nxt;
            end else if (state_nxt == ST_SEND_B) begin
                o_mlt <= b_q;
            end
            if (state == ST_SEND_B) begin
                pair_cnt <= sat_inc(pair_cnt);
            end
            if (drop) begin
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    assign o_dval  = (state == ST_SEND_A) || (state == ST_SEND_B);
    assign o_phase = (state == ST_SEND_B);
    assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_tdc_pair_sched.sv
// Directed-vector bench for tdc_pair_sched with hand-computed expectations.
module tb_tdc_pair_sched;

    logic        clk;
    logic        rst;
    logic        en;
    logic        a_vld;
    logic [36:0] a_stamp;
    logic        b_vld;
    logic [36:0] b_stamp;
    logic        o_dval;
    logic [36:0] o_mlt;
    logic        o_phase;
    logic        busy;
    logic [15:0] pair_cnt;
    logic [15:0] drop_cnt;

    int total = 0;
    int bad   = 0;
    int exp_drop;
    int exp_pair;

    tdc_pair_sched #(.STAMP_W(37), .TIMEOUT(16'd8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .a_vld    (a_vld),
        .a_stamp  (a_stamp),
        .b_vld    (b_vld),
        .b_stamp  (b_stamp),
        .o_dval   (o_dval),
        .o_mlt    (o_mlt),
        .o_phase  (o_phase),
        .busy     (busy),
        .pair_cnt (pair_cnt),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic dv, input logic [36:0] mlt, input logic ph);
        chk({tag, ".dval"}, 64'(o_dval), 64'(dv));
        chk({tag, ".mlt"}, 64'(o_mlt), 64'(mlt));
        chk({tag, ".phase"}, 64'(o_phase), 64'(ph));
    endtask

    task automatic chk_cnt(input string tag, input int pairs, input int drops);
        chk({tag, ".pair"}, 64'(pair_cnt), 64'(pairs));
        chk({tag, ".drop"}, 64'(drop_cnt), 64'(drops));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
        a_stamp = '0; b_stamp = '0;
        repeat (2) tick();
        chk_word("rst", 1'b0, 37'd0, 1'b0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk_cnt("rst", 0, 0);

        // Basic pair; start captured on the first edge after reset release.
        rst = 1'b0; en = 1'b1; a_vld = 1'b1; a_stamp = 37'd100;
        tick();
        a_vld = 1'b0;
        chk("s1.busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s1.wait_dval", 64'(o_dval), 64'd0);
        end
        b_vld = 1'b1; b_stamp = 37'd250;
        tick();
        b_vld = 1'b0;
        chk_word("s1.start", 1'b1, 37'd100, 1'b0);
        tick();
        chk_word("s1.stop", 1'b1, 37'd250, 1'b1);
        tick();
        chk_word("s1.idle", 1'b0, 37'd250, 1'b1 & o_phase);
        chk("s1.idle_phase", 64'(o_phase), 64'd0);
        chk("s1.busy_end", 64'(busy), 64'd0);
        chk_cnt("s1", 1, 0);

        // Same-cycle start and stop.
        a_vld = 1'b1; b_vld = 1'b1; a_stamp = 37'd7; b_stamp = 37'd9;
        tick();
        a_vld = 1'b0; b_vld = 1'b0;
        chk_word("s2.start", 1'b1, 37'd7, 1'b0);
        tick();
        chk_word("s2.stop", 1'b1, 37'd9, 1'b1);
        tick();
        chk("s2.dval_end", 64'(o_dval), 64'd0);
        chk_cnt("s2", 2, 0);

        // Orphan stop, then a second start while waiting.
        b_vld = 1'b1; b_stamp = 37'd55;
        tick();
        b_vld = 1'b0;
        chk("s3.busy_orphan", 64'(busy), 64'd0);
        chk_cnt("s3.orphan", 2, 1);
        a_vld = 1'b1; a_stamp = 37'd300;
        tick();
        a_stamp = 37'd400;
        tick();
        a_vld = 1'b0;
        chk("s3.busy_wait", 64'(busy), 64'd1);
        chk_cnt("s3.second_a", 2, 2);
        b_vld = 1'b1; b_stamp = 37'd500;
        tick();
        b_vld = 1'b0;
        chk_word("s3.start", 1'b1, 37'd300, 1'b0);
        tick();
        chk_word("s3.stop", 1'b1, 37'd500, 1'b1);
        tick();
        chk_cnt("s3", 3, 2);

        // Strobes during the send states: two at once count once.
        a_vld = 1'b1; b_vld = 1'b1; a_stamp = 37'd11; b_stamp = 37'd12;
        tick();
        a_stamp = 37'd66; b_stamp = 37'd67;
        tick();
        b_vld = 1'b0;
        chk_word("s4.stop", 1'b1, 37'd12, 1'b1);
        chk_cnt("s4.send_a", 3, 3);
        tick();
        a_vld = 1'b0;
        chk("s4.busy", 64'(busy), 64'd0);
        chk_cnt("s4", 4, 4);

        // Start ignored while the window is closed.
        en = 1'b0; a_vld = 1'b1; a_stamp = 37'd90;
        tick();
        a_vld = 1'b0;
        chk("s5.busy", 64'(busy), 64'd0);
        chk_cnt("s5", 4, 4);

        // Window closing while waiting for a stop.
        en = 1'b1; a_vld = 1'b1; a_stamp = 37'd20;
        tick();
        a_vld = 1'b0; en = 1'b0;
        chk("s6.busy_wait", 64'(busy), 64'd1);
        tick();
        tick();
`ifdef TDC_PAIR_TIMEOUT_EN
        chk("s6.busy_abort", 64'(busy), 64'd0);
        exp_pair = 4; exp_drop = 5;
`else
        chk("s6.busy_hold", 64'(busy), 64'd1);
        b_vld = 1'b1; b_stamp = 37'd30;
        tick();
        b_vld = 1'b0;
        chk_word("s6.start", 1'b1, 37'd20, 1'b0);
        tick();
        chk_word("s6.stop", 1'b1, 37'd30, 1'b1);
        tick();
        exp_pair = 5; exp_drop = 4;
`endif
        chk_cnt("s6", exp_pair, exp_drop);
        en = 1'b1;

`ifdef TDC_PAIR_TIMEOUT_EN
        // Watchdog: busy lasts TIMEOUT cycles, no word emitted.
        begin
            int n;
            n = 0;
            a_vld = 1'b1; a_stamp = 37'd44;
            tick();
            a_vld = 1'b0;
            for (int i = 0; i < 20 && busy; i++) begin
                n++;
                chk("s7.dval", 64'(o_dval), 64'd0);
                tick();
            end
            chk("s7.busy_cycles", 64'(n), 64'd8);
            chk_cnt("s7", exp_pair, exp_drop + 1);
        end
`endif

        // Reset during SEND_A, then a clean pair.
        a_vld = 1'b1; b_vld = 1'b1; a_stamp = 37'h1234; b_stamp = 37'h5678;
        tick();
        a_vld = 1'b0; b_vld = 1'b0;
        chk_word("s8.start", 1'b1, 37'h1234, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk_word("s8.rst", 1'b0, 37'd0, 1'b0);
        chk("s8.busy", 64'(busy), 64'd0);
        chk_cnt("s8.rst", 0, 0);
        tick();
        chk("s8.no_stop", 64'(o_dval), 64'd0);
        rst = 1'b0; a_vld = 1'b1; b_vld = 1'b1; a_stamp = 37'd77; b_stamp = 37'd88;
        tick();
        a_vld = 1'b0; b_vld = 1'b0;
        chk_word("s8.start2", 1'b1, 37'd77, 1'b0);
        tick();
        chk_word("s8.stop2", 1'b1, 37'd88, 1'b1);
        tick();
        chk_cnt("s8", 1, 0);

        // drop_cnt saturation via continuous orphan stops.
        b_vld = 1'b1; b_stamp = 37'd1;
        repeat (65534) tick();
        chk("s9.drop_fffe", 64'(drop_cnt), 64'hFFFE);
        tick();
        chk("s9.drop_ffff", 64'(drop_cnt), 64'hFFFF);
        tick();
        b_vld = 1'b0;
        chk("s9.drop_sat", 64'(drop_cnt), 64'hFFFF);
        chk("s9.pair", 64'(pair_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
